// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, keeps one aligned block request in flight to the
// I-cache and forwards the lane-masked packet to the fetch buffer when it has room.
module inst_fetch #(
  parameter int unsigned     FETCH_WIDTH = 4,
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h8000_0000
) (
  input  logic                        clock,
  input  logic                        reset,
  output logic                        icache_req_valid,
  output logic [XLEN-1:0]             icache_req_addr,
  input  logic                        icache_req_ready,
  input  logic                        icache_resp_valid,
  input  logic [FETCH_WIDTH*32-1:0]   icache_resp_data,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  input  logic                        fb_full,
  output logic                        insts_out_valid,
  output logic [FETCH_WIDTH*32-1:0]   insts_out_inst,
  output logic [FETCH_WIDTH*XLEN-1:0] insts_out_pc,
  output logic [FETCH_WIDTH-1:0]      insts_out_lane_valid
);

  localparam int unsigned     OFF_W       = $clog2(FETCH_WIDTH * 4);
  localparam int unsigned     LANE_W      = OFF_W - 2;
  localparam logic [XLEN-1:0] BLOCK_BYTES = XLEN'(FETCH_WIDTH * 4);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } state_e;

  state_e                      state_r;
  state_e                      next_state_s;
  logic [XLEN-1:0]             pc_r;
  logic [XLEN-1:0]             block_addr_r;
  logic [LANE_W-1:0]           offset_r;
  logic [FETCH_WIDTH*32-1:0]   hold_data_r;
  logic [XLEN-1:0]             aligned_pc_s;
  logic [FETCH_WIDTH-1:0]      lane_mask_s;
  logic                        send_s;
  logic                        unused_pc_bits_s;

  assign aligned_pc_s     = {pc_r[XLEN-1:OFF_W], {OFF_W{1'b0}}};
  assign send_s           = (state_r == HOLD) && !fb_full && !redirect_valid;
  // Instructions are 4-byte aligned, so the two lowest PC bits carry no information.
  assign unused_pc_bits_s = ^pc_r[1:0];

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a redirect outranks every other transition.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: next_state_s = REQ;
      REQ: begin
        if (redirect_valid) begin
          next_state_s = icache_req_ready ? DROP : REQ;
        end else if (icache_req_ready) begin
          next_state_s = WAIT;
        end else begin
          next_state_s = REQ;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          next_state_s = icache_resp_valid ? REQ : DROP;
        end else if (icache_resp_valid) begin
          next_state_s = HOLD;
        end else begin
          next_state_s = WAIT;
        end
      end
      HOLD: begin
        if (redirect_valid || !fb_full) begin
          next_state_s = REQ;
        end else begin
          next_state_s = HOLD;
        end
      end
      DROP: next_state_s = icache_resp_valid ? REQ : DROP;
      default: next_state_s = IDLE;
    endcase
  end

  // PC, accepted-block bookkeeping and packet hold register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_r         <= RESET_PC;
      block_addr_r <= '0;
      offset_r     <= '0;
      hold_data_r  <= '0;
    end else begin
      if (redirect_valid) begin
        pc_r <= redirect_pc;
      end else if (send_s) begin
        pc_r <= block_addr_r + BLOCK_BYTES;
      end
      if ((state_r == REQ) && icache_req_ready && !redirect_valid) begin
        block_addr_r <= aligned_pc_s;
        offset_r     <= pc_r[OFF_W-1:2];
      end
      if ((state_r == WAIT) && icache_resp_valid && !redirect_valid) begin
        hold_data_r <= icache_resp_data;
      end
    end
  end

  // Lanes ahead of an unaligned entry PC are masked off.
  always_comb begin
    lane_mask_s = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_mask_s[i] = (i >= int'(offset_r));
    end
  end

  // Output decode; everything is forced quiet while reset is asserted.
  always_comb begin
    icache_req_valid     = 1'b0;
    insts_out_valid      = 1'b0;
    insts_out_lane_valid = '0;
    if (reset) begin
      case (state_r)
        REQ: icache_req_valid = 1'b1;
        HOLD: begin
          insts_out_valid      = send_s;
          insts_out_lane_valid = lane_mask_s;
        end
        default: begin
          icache_req_valid     = 1'b0;
          insts_out_valid      = 1'b0;
          insts_out_lane_valid = '0;
        end
      endcase
    end else begin
      icache_req_valid     = 1'b0;
      insts_out_valid      = 1'b0;
      insts_out_lane_valid = '0;
    end
  end

  assign icache_req_addr = aligned_pc_s;
  assign insts_out_inst  = hold_data_r;

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane_pc
    assign insts_out_pc[g*XLEN +: XLEN] = block_addr_r + XLEN'(g * 32'd4);
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized run scored
// against a transaction-level model of the fetch stream.
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic          clock;
  logic          reset;
  logic          icache_req_valid;
  logic [31:0]   icache_req_addr;
  logic          icache_req_ready;
  logic          icache_resp_valid;
  logic [127:0]  icache_resp_data;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          fb_full;
  logic          insts_out_valid;
  logic [127:0]  insts_out_inst;
  logic [127:0]  insts_out_pc;
  logic [3:0]    insts_out_lane_valid;

  int vectors    = 0;
  int miscompares = 0;

  // I-cache model state
  bit           c_pend = 1'b0;
  int           c_lat = 0;
  logic [127:0] c_data = '0;
  int           cfg_lat_min = 1;
  int           cfg_lat_max = 1;
  bit           cfg_force = 1'b0;
  logic [127:0] cfg_data = '0;
  logic [127:0] last_resp_data = '0;

  // per-cycle snapshot
  logic         s_req_valid, s_out_valid, s_resp_valid, s_rdy, s_fbf, s_rdv;
  logic [31:0]  s_req_addr, s_rpc;
  logic [127:0] s_out_inst, s_out_pc, s_resp_data;
  logic [3:0]   s_lane;

  inst_fetch dut (
    .clock                (clock),
    .reset                (reset),
    .icache_req_valid     (icache_req_valid),
    .icache_req_addr      (icache_req_addr),
    .icache_req_ready     (icache_req_ready),
    .icache_resp_valid    (icache_resp_valid),
    .icache_resp_data     (icache_resp_data),
    .redirect_valid       (redirect_valid),
    .redirect_pc          (redirect_pc),
    .fb_full              (fb_full),
    .insts_out_valid      (insts_out_valid),
    .insts_out_inst       (insts_out_inst),
    .insts_out_pc         (insts_out_pc),
    .insts_out_lane_valid (insts_out_lane_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [127:0] rand128();
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // lane i holds a real instruction when it is at or beyond the entry PC's word slot
  function automatic logic [3:0] exp_mask(input logic [31:0] pc);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (i >= int'(pc[3:2]));
    return m;
  endfunction

  // One clock: drive inputs at negedge, sample outputs, advance the cache model at posedge.
  task automatic tick(input logic rdy, input logic fbf, input logic rdv, input logic [31:0] rpc);
    icache_req_ready  = rdy;
    fb_full           = fbf;
    redirect_valid    = rdv;
    redirect_pc       = rpc;
    icache_resp_valid = c_pend && (c_lat == 0);
    icache_resp_data  = icache_resp_valid ? c_data : rand128();
    #1;
    s_req_valid = icache_req_valid;   s_req_addr = icache_req_addr;
    s_out_valid = insts_out_valid;    s_out_inst = insts_out_inst;
    s_out_pc    = insts_out_pc;       s_lane     = insts_out_lane_valid;
    s_resp_valid = icache_resp_valid; s_resp_data = icache_resp_data;
    s_rdy = rdy; s_fbf = fbf; s_rdv = rdv; s_rpc = rpc;
    if (s_resp_valid) last_resp_data = s_resp_data;
    @(posedge clock);
    if (!reset || s_resp_valid) c_pend = 1'b0;
    else if (c_pend) c_lat--;
    if (reset && s_req_valid && rdy) begin
      c_pend = 1'b1;
      c_lat  = int'($urandom_range(cfg_lat_max, cfg_lat_min)) - 1;
      c_data = cfg_force ? cfg_data : rand128();
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 1'b0, 1'b1, 32'h1234_5670);
      vectors++;
      if (s_req_valid !== 1'b0 || s_out_valid !== 1'b0 || s_lane !== 4'h0) begin
        miscompares++;
        $display("FAIL reset_outputs: got req=%b out=%b lane=%h, expected 0/0/0", s_req_valid, s_out_valid, s_lane);
      end
    end
    reset = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    vectors++;
    if (s_req_valid !== 1'b0 || s_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got req=%b out=%b, expected 0/0", s_req_valid, s_out_valid);
    end
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    vectors++;
    if (s_req_valid !== 1'b1 || s_req_addr !== RST_PC) begin
      miscompares++;
      $display("FAIL reset_first_req: got valid=%b addr=%h, expected 1 %h", s_req_valid, s_req_addr, RST_PC);
    end
  endtask

  task automatic test_sequential();
    int nreq = 0;
    int npkt = 0;
    int last_pkt_cyc = -1;
    logic [31:0] base;
    cfg_lat_min = 1; cfg_lat_max = 1;
    do_reset();
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      if (s_req_valid) begin
        vectors++;
        if (s_req_addr !== RST_PC + 32'(nreq * 16)) begin
          miscompares++;
          $display("FAIL seq_req_addr: got %h, expected %h", s_req_addr, RST_PC + 32'(nreq * 16));
        end
        nreq++;
      end
      if (s_out_valid) begin
        base = RST_PC + 32'(npkt * 16);
        vectors++;
        if (s_lane !== 4'b1111 || s_out_inst !== last_resp_data) begin
          miscompares++;
          $display("FAIL seq_packet: got lane=%h inst=%h, expected 1111 %h", s_lane, s_out_inst, last_resp_data);
        end
        for (int i = 0; i < 4; i++) begin
          vectors++;
          if (s_out_pc[i*32 +: 32] !== base + 32'(4 * i)) begin
            miscompares++;
            $display("FAIL seq_lane_pc: lane %0d got %h, expected %h", i, s_out_pc[i*32 +: 32], base + 32'(4 * i));
          end
        end
        vectors++;
        if ((last_pkt_cyc >= 0) ? (cyc - last_pkt_cyc != 3) : (cyc != 3)) begin
          miscompares++;
          $display("FAIL seq_spacing: packet at cycle %0d, previous %0d, expected 3 apart from cycle 3", cyc, last_pkt_cyc);
        end
        last_pkt_cyc = cyc;
        npkt++;
      end
    end
    vectors++;
    if (nreq != 3 || npkt != 3) begin
      miscompares++;
      $display("FAIL seq_counts: got %0d requests %0d packets, expected 3 3", nreq, npkt);
    end
  endtask

  task automatic test_redirect_req(input logic [31:0] tgt);
    bit got = 1'b0;
    logic [31:0] blk;
    blk = tgt & 32'hFFFF_FFF0;
    cfg_lat_min = 1; cfg_lat_max = 2;
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b1, tgt);
    for (int k = 0; k < 12 && !got; k++) begin
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      if (k == 0) begin
        vectors++;
        if (s_req_valid !== 1'b1 || s_req_addr !== blk) begin
          miscompares++;
          $display("FAIL redir_req_addr: got valid=%b addr=%h, expected 1 %h", s_req_valid, s_req_addr, blk);
        end
      end
      if (s_out_valid) begin
        got = 1'b1;
        vectors++;
        if (s_lane !== exp_mask(tgt) || s_out_inst !== last_resp_data) begin
          miscompares++;
          $display("FAIL redir_packet: got lane=%b inst=%h, expected %b %h", s_lane, s_out_inst, exp_mask(tgt), last_resp_data);
        end
        for (int i = 0; i < 4; i++) begin
          vectors++;
          if (s_out_pc[i*32 +: 32] !== blk + 32'(4 * i)) begin
            miscompares++;
            $display("FAIL redir_lane_pc: lane %0d got %h, expected %h", i, s_out_pc[i*32 +: 32], blk + 32'(4 * i));
          end
        end
      end
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL redir_timeout: no packet within 12 cycles for target %h", tgt);
    end else begin
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      vectors++;
      if (s_req_valid !== 1'b1 || s_req_addr !== blk + 32'h10) begin
        miscompares++;
        $display("FAIL redir_next_req: got valid=%b addr=%h, expected 1 %h", s_req_valid, s_req_addr, blk + 32'h10);
      end
    end
  endtask

  task automatic test_fb_full();
    logic [127:0] held;
    cfg_lat_min = 1; cfg_lat_max = 1;
    do_reset();
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    held = last_resp_data;
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      vectors++;
      if (s_out_valid !== 1'b0 || s_req_valid !== 1'b0 || s_lane !== 4'hF || s_out_inst !== held) begin
        miscompares++;
        $display("FAIL full_stall: cycle %0d got out=%b req=%b lane=%h inst=%h, expected 0 0 f %h",
                 k, s_out_valid, s_req_valid, s_lane, s_out_inst, held);
      end
    end
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    vectors++;
    if (s_out_valid !== 1'b1 || s_out_inst !== held || s_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_release: got out=%b req=%b inst=%h, expected 1 0 %h", s_out_valid, s_req_valid, s_out_inst, held);
    end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    vectors++;
    if (s_out_valid !== 1'b0 || s_req_valid !== 1'b1 || s_req_addr !== RST_PC + 32'h10) begin
      miscompares++;
      $display("FAIL full_after: got out=%b req=%b addr=%h, expected 0 1 %h", s_out_valid, s_req_valid, s_req_addr, RST_PC + 32'h10);
    end
  endtask

  task automatic test_redirect_wait();
    logic [127:0] bad;
    bit got = 1'b0;
    bad = {4{32'hDEAD_BEEF}};
    cfg_lat_min = 4; cfg_lat_max = 4; cfg_force = 1'b1; cfg_data = bad;
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b1, 32'h8000_0200);
    cfg_lat_min = 1; cfg_lat_max = 1; cfg_force = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      vectors++;
      if (s_req_valid !== 1'b0 || s_out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL drop_quiet: cycle %0d got req=%b out=%b, expected 0 0", k, s_req_valid, s_out_valid);
      end
    end
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    vectors++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h8000_0200) begin
      miscompares++;
      $display("FAIL drop_next_req: got valid=%b addr=%h, expected 1 80000200", s_req_valid, s_req_addr);
    end
    for (int k = 0; k < 6 && !got; k++) begin
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      if (s_out_valid) begin
        got = 1'b1;
        vectors++;
        if (s_out_inst === bad || s_out_inst !== last_resp_data || s_out_pc[31:0] !== 32'h8000_0200) begin
          miscompares++;
          $display("FAIL drop_packet: got inst=%h pc0=%h, expected %h 80000200", s_out_inst, s_out_pc[31:0], last_resp_data);
        end
      end
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL drop_timeout: packet for 80000200 not delivered within 6 cycles");
    end
  endtask

  task automatic test_redirect_resp();
    cfg_lat_min = 2; cfg_lat_max = 2;
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b1, 32'h8000_0340);
    vectors++;
    if (s_out_valid !== 1'b0 || s_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL coinc_cycle: got out=%b req=%b, expected 0 0", s_out_valid, s_req_valid);
    end
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    vectors++;
    if (s_req_valid !== 1'b1 || s_req_addr !== 32'h8000_0340 || s_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL coinc_next_req: got req=%b addr=%h out=%b, expected 1 80000340 0", s_req_valid, s_req_addr, s_out_valid);
    end
  endtask

  task automatic test_reset_mid();
    cfg_lat_min = 1; cfg_lat_max = 1;
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 1'b1, 32'h1234_5678);
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      vectors++;
      if (s_req_valid !== 1'b1 || s_req_addr !== 32'h1234_5670) begin
        miscompares++;
        $display("FAIL stall_addr: cycle %0d got valid=%b addr=%h, expected 1 12345670", k, s_req_valid, s_req_addr);
      end
    end
    reset = 1'b0;
    tick(1'b1, 1'b0, 1'b1, 32'h5555_5550);
    vectors++;
    if (s_req_valid !== 1'b0 || s_out_valid !== 1'b0 || s_lane !== 4'h0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got req=%b out=%b lane=%h, expected 0 0 0", s_req_valid, s_out_valid, s_lane);
    end
    reset = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    vectors++;
    if (s_req_valid !== 1'b1 || s_req_addr !== RST_PC) begin
      miscompares++;
      $display("FAIL midreset_first_req: got valid=%b addr=%h, expected 1 %h", s_req_valid, s_req_addr, RST_PC);
    end
  endtask

  // Random traffic scored against the fetch-stream model: the next packet must start at
  // exp_pc, a redirect replaces exp_pc and kills anything older, one request at a time.
  task automatic test_random();
    logic [31:0]  exp_pc;
    logic [31:0]  blk;
    logic [31:0]  rpc;
    logic [127:0] pkt_data;
    bit           pkt;
    bit           req_live;
    bit           pend_pre;
    bit           exp_out;
    logic         rdy, fbf, rdv;
    cfg_lat_min = 1; cfg_lat_max = 4; cfg_force = 1'b0;
    do_reset();
    tick(1'b0, 1'b0, 1'b0, 32'h0);
    exp_pc = RST_PC; pkt = 1'b0; req_live = 1'b0; pkt_data = '0;
    for (int n = 0; n < 3000; n++) begin
      rdy = ($urandom_range(9, 0) < 7);
      fbf = ($urandom_range(9, 0) < 3);
      rdv = ($urandom_range(99, 0) < 6);
      case ($urandom_range(3, 0))
        0:       rpc = RST_PC + ($urandom_range(255, 0) << 2);
        1:       rpc = 32'hFFFF_FFF0 + ($urandom_range(3, 0) << 2);
        2:       rpc = $urandom & 32'hFFFF_FFFC;
        default: rpc = 32'h0000_0100 + ($urandom_range(63, 0) << 2);
      endcase
      pend_pre = c_pend;
      blk = exp_pc & 32'hFFFF_FFF0;
      tick(rdy, fbf, rdv, rpc);
      vectors++;
      if (s_req_valid !== (!pend_pre && !pkt)) begin
        miscompares++;
        $display("FAIL rnd_req_valid: cycle %0d got %b, expected %b", n, s_req_valid, !pend_pre && !pkt);
      end
      if (s_req_valid) begin
        vectors++;
        if (s_req_addr !== blk) begin
          miscompares++;
          $display("FAIL rnd_req_addr: cycle %0d got %h, expected %h", n, s_req_addr, blk);
        end
      end
      exp_out = pkt && !fbf && !rdv;
      vectors++;
      if (s_out_valid !== exp_out || s_lane !== (pkt ? exp_mask(exp_pc) : 4'h0)) begin
        miscompares++;
        $display("FAIL rnd_out_valid: cycle %0d got valid=%b lane=%b, expected %b %b",
                 n, s_out_valid, s_lane, exp_out, pkt ? exp_mask(exp_pc) : 4'h0);
      end
      if (exp_out && s_out_valid) begin
        vectors++;
        if (s_out_inst !== pkt_data || s_out_pc !== {blk + 32'hC, blk + 32'h8, blk + 32'h4, blk}) begin
          miscompares++;
          $display("FAIL rnd_packet: cycle %0d got inst=%h pc=%h, expected %h base %h", n, s_out_inst, s_out_pc, pkt_data, blk);
        end
      end
      if (exp_out) begin
        exp_pc = blk + 32'h10;
        pkt = 1'b0;
      end
      if (s_resp_valid) begin
        if (req_live && !rdv) begin
          pkt = 1'b1;
          pkt_data = s_resp_data;
        end
        req_live = 1'b0;
      end
      if (s_req_valid && rdy) req_live = !rdv;
      if (rdv) begin
        exp_pc = rpc;
        pkt = 1'b0;
        req_live = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b0; icache_req_ready = 1'b0; icache_resp_valid = 1'b0; icache_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; fb_full = 1'b0;
    @(negedge clock);
    test_reset();
    test_sequential();
    test_redirect_req(32'h8000_0108);
    test_redirect_req(32'hFFFF_FFF8);
    test_fb_full();
    test_redirect_wait();
    test_redirect_resp();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
